// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug dump logic:
// default geometry, FSM state encoding and index wrap helper.
package rf_dbg_pkg;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ADDR_W_DEF   = 6;
  localparam int unsigned DATA_W_DEF   = 32;

  // Legacy state encodings; the enum below is bound to these values.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_CSUM  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    FETCH = S_FETCH,
    SEND  = S_SEND,
    CSUM  = S_CSUM
  } state_t;

  // Successor of a register index, wrapping at num_regs.
  function automatic int unsigned next_idx(input int unsigned idx,
                                           input int unsigned num_regs);
    return (idx + 32'd1 >= num_regs) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rf_dump_csum.sv
// XOR accumulator over the register words delivered during a dump.
// Exposes the post-update value so the caller can load it in the same
// cycle as the final register word is accepted.
module rf_dump_csum
  import rf_dbg_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum_next
);

  logic [DATA_W-1:0] acc;

  // Value the accumulator will hold after this cycle's word (if any).
  always_comb begin
    sum_next = en ? (acc ^ din) : acc;
  end

  // Accumulator register: cleared on a new dump, otherwise follows sum_next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else begin
      acc <= sum_next;
    end
  end

endmodule

// File: rtl/rf_dump_reader.sv
// Register-file dump reader: walks first..last (wrapping modulo NUM_REGS)
// through one rf read port and streams each word over valid/ready.
// Optional trailing XOR checksum word when RF_DUMP_CHECKSUM_EN is defined.
module rf_dump_reader
  import rf_dbg_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_idx,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

`ifdef RF_DUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  state_t            state;
  logic [ADDR_W-1:0] last_r;
  logic [ADDR_W-1:0] first_mod;
  logic [ADDR_W-1:0] last_mod;
  logic [ADDR_W-1:0] idx_succ;
  logic              accept_start;
  logic              handshake;

  // Range reduction, successor index and qualified events.
  always_comb begin
    first_mod    = ADDR_W'(32'(first_idx) % NUM_REGS);
    last_mod     = ADDR_W'(32'(last_idx) % NUM_REGS);
    idx_succ     = ADDR_W'(next_idx(32'(dump_idx), NUM_REGS));
    accept_start = (state == IDLE) && start;
    handshake    = dump_valid && dump_ready && !abort;
    busy         = (state != IDLE);
  end

`ifdef RF_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_next;

  rf_dump_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept_start),
    .en       ((state == SEND) && handshake),
    .din      (dump_data),
    .sum_next (csum_next)
  );
`endif

  // Dump FSM; abort takes priority over any handshake in a busy state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_r     <= '0;
      rd_addr    <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_idx   <= '0;
      dump_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state      <= IDLE;
        dump_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              last_r  <= last_mod;
              rd_addr <= first_mod;
              state   <= FETCH;
            end
          end
          FETCH: begin
            dump_data  <= rd_data;
            dump_idx   <= rd_addr;
            dump_last  <= (rd_addr == last_r) && !CSUM_EN;
            dump_valid <= 1'b1;
            state      <= SEND;
          end
          SEND: begin
            if (handshake) begin
              if (dump_idx != last_r) begin
                dump_valid <= 1'b0;
                rd_addr    <= idx_succ;
                state      <= FETCH;
              end else begin
`ifdef RF_DUMP_CHECKSUM_EN
                // Valid stays high: the checksum word follows back-to-back.
                dump_data <= csum_next;
                dump_idx  <= last_r;
                dump_last <= 1'b1;
                state     <= CSUM;
`else
                dump_valid <= 1'b0;
                done       <= 1'b1;
                state      <= IDLE;
`endif
              end
            end
          end
`ifdef RF_DUMP_CHECKSUM_EN
          CSUM: begin
            if (handshake) begin
              dump_valid <= 1'b0;
              done       <= 1'b1;
              state      <= IDLE;
            end
          end
`endif
          default: begin
            dump_valid <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed testbench for rf_dump_reader (default and RF_DUMP_CHECKSUM_EN builds).
module tb_rf_dump_reader;

`ifdef RF_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  first_idx;
  logic [5:0]  last_idx;
  logic        abort;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [5:0]  dump_idx;
  logic        dump_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [64];
  int          n_tests = 0;
  int          n_fail  = 0;

  rf_dump_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_idx  (first_idx),
    .last_idx   (last_idx),
    .abort      (abort),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_idx   (dump_idx),
    .dump_last  (dump_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign rd_data = rf[rd_addr];

  task automatic chk(input string tag, input bit ok,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && dump_valid !== 1'b1; i++) step();
    chk({tag, "_valid"}, dump_valid === 1'b1, dump_valid, 1'b1);
  endtask

  // Full dump with dump_ready=1; optionally pokes start while busy.
  task automatic dump_and_check(input string tag, input logic [5:0] f,
                                input logic [5:0] l, input int n, input bit poke);
    logic [5:0]  idx;
    logic [31:0] acc;
    logic        exp_last;
    first_idx = f;
    last_idx  = l;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_lat1_valid"}, dump_valid === 1'b0, dump_valid, 1'b0);
    chk({tag, "_busy"}, busy === 1'b1, busy, 1'b1);
    step();
    chk({tag, "_lat2_valid"}, dump_valid === 1'b1, dump_valid, 1'b1);
    idx = f;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      wait_valid(tag);
      exp_last = (k == n - 1) && !CSUM;
      chk({tag, "_data"}, dump_data === rf[idx], dump_data, rf[idx]);
      chk({tag, "_idx"}, dump_idx === idx, dump_idx, idx);
      chk({tag, "_last"}, dump_last === exp_last, dump_last, exp_last);
      chk({tag, "_nodone"}, done === 1'b0, done, 1'b0);
      if (poke && k == 1) begin
        first_idx = 6'd0;
        last_idx  = 6'd0;
        start     = 1'b1;
      end
      acc = acc ^ rf[idx];
      step();
      start = 1'b0;
      idx   = (idx == 6'd31) ? 6'd0 : idx + 6'd1;
    end
    if (CSUM) begin
      wait_valid({tag, "_cs"});
      chk({tag, "_cs_data"}, dump_data === acc, dump_data, acc);
      chk({tag, "_cs_idx"}, dump_idx === l, dump_idx, l);
      chk({tag, "_cs_last"}, dump_last === 1'b1, dump_last, 1'b1);
      step();
    end
    chk({tag, "_done"}, done === 1'b1, done, 1'b1);
    chk({tag, "_idle"}, busy === 1'b0, busy, 1'b0);
    chk({tag, "_valid_off"}, dump_valid === 1'b0, dump_valid, 1'b0);
    step();
    chk({tag, "_done_pulse"}, done === 1'b0, done, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = 32'h0;
    rf[4]  = 32'h11;
    rf[5]  = 32'h22;
    rf[6]  = 32'h33;
    rf[7]  = 32'hDEADBEEF;
    rf[30] = 32'hA;
    rf[31] = 32'hB;
    rf[1]  = 32'hC;
    reset = 1'b1; start = 1'b0; abort = 1'b0; dump_ready = 1'b1;
    first_idx = '0; last_idx = '0;
    #12;
    chk("rst_valid", dump_valid === 1'b0, dump_valid, 1'b0);
    chk("rst_busy", busy === 1'b0, busy, 1'b0);
    chk("rst_done", done === 1'b0, done, 1'b0);
    chk("rst_rd_addr", rd_addr === 6'd0, rd_addr, 6'd0);
    chk("rst_data", dump_data === 32'd0, dump_data, 32'd0);
    chk("rst_idx", dump_idx === 6'd0, dump_idx, 6'd0);
    chk("rst_last", dump_last === 1'b0, dump_last, 1'b0);
    step();
    reset = 1'b0;
    step();

    // Basic 4..6 dump.
    dump_and_check("r4_6", 6'd4, 6'd6, 3, 1'b0);
    chk("rd_addr_hold", rd_addr === 6'd6, rd_addr, 6'd6);

    // Wrap-around 30..1, including index 0.
    dump_and_check("wrap", 6'd30, 6'd1, 4, 1'b0);

    // Single word with back-pressure.
    first_idx = 6'd7; last_idx = 6'd7; dump_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", dump_valid === 1'b1, dump_valid, 1'b1);
      chk("bp_data", dump_data === 32'hDEADBEEF, dump_data, 32'hDEADBEEF);
      chk("bp_idx", dump_idx === 6'd7, dump_idx, 6'd7);
      chk("bp_last", dump_last === !CSUM, dump_last, !CSUM);
      step();
    end
    dump_ready = 1'b1;
    step();
    if (CSUM) begin
      chk("bp_cs_data", dump_data === 32'hDEADBEEF, dump_data, 32'hDEADBEEF);
      chk("bp_cs_last", dump_last === 1'b1, dump_last, 1'b1);
      step();
    end
    chk("bp_done", done === 1'b1, done, 1'b1);
    chk("bp_valid_off", dump_valid === 1'b0, dump_valid, 1'b0);
    step();

    // Abort in the second SEND, coinciding with a handshake.
    first_idx = 6'd4; last_idx = 6'd6; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("ab_pre_idx", dump_idx === 6'd5, dump_idx, 6'd5);
    chk("ab_pre_valid", dump_valid === 1'b1, dump_valid, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_valid", dump_valid === 1'b0, dump_valid, 1'b0);
    chk("ab_busy", busy === 1'b0, busy, 1'b0);
    chk("ab_done", done === 1'b0, done, 1'b0);
    step();
    chk("ab_done2", done === 1'b0, done, 1'b0);
    chk("ab_valid2", dump_valid === 1'b0, dump_valid, 1'b0);
    dump_and_check("post_ab", 6'd30, 6'd31, 2, 1'b0);

    // Same scenario, reset instead of abort.
    first_idx = 6'd4; last_idx = 6'd6; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("rs_pre_idx", dump_idx === 6'd5, dump_idx, 6'd5);
    reset = 1'b1;
    #1;
    chk("rs_valid", dump_valid === 1'b0, dump_valid, 1'b0);
    chk("rs_busy", busy === 1'b0, busy, 1'b0);
    chk("rs_data", dump_data === 32'd0, dump_data, 32'd0);
    chk("rs_idx", dump_idx === 6'd0, dump_idx, 6'd0);
    chk("rs_rd_addr", rd_addr === 6'd0, rd_addr, 6'd0);
    chk("rs_done", done === 1'b0, done, 1'b0);
    step();
    reset = 1'b0;
    step();

    // start and abort together in IDLE: start wins.
    first_idx = 6'd4; last_idx = 6'd4; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy === 1'b1, busy, 1'b1);
    step();
    chk("sa_idx", dump_idx === 6'd4, dump_idx, 6'd4);
    chk("sa_data", dump_data === 32'h11, dump_data, 32'h11);
    for (int i = 0; i < 8 && busy === 1'b1; i++) step();
    chk("sa_idle", busy === 1'b0, busy, 1'b0);
    step();

    // start while busy is ignored.
    dump_and_check("poke", 6'd4, 6'd6, 3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
